// File: rtl/his_peak_finder_pkg.sv
// rtl/his_peak_finder_pkg.sv - shared widths and stream status encodings for the histogram peak finder
package his_peak_finder_pkg;

    localparam int NP_DEF       = 8;
    localparam int PEAK_MAX_DEF = 8;
    localparam int NB_DEF       = 16;

    localparam logic [1:0] DF_IDLE = 2'b00;
    localparam logic [1:0] DF_CH   = 2'b01;
    localparam logic [1:0] DF_FH   = 2'b10;
    localparam logic [1:0] DF_END  = 2'b11;

endpackage

// File: rtl/his_max_tracker.sv
// rtl/his_max_tracker.sv - running (count, addr) maximum with init and strict-greater update
module his_max_tracker #(
    parameter int NP       = 8,
    parameter int PEAK_MAX = 8
) (
    input  logic                clk,
    input  logic                res,
    input  logic                init,
    input  logic                en,
    input  logic [PEAK_MAX-1:0] in_cnt,
    input  logic [NP-1:0]       in_addr,
    output logic [PEAK_MAX-1:0] max_cnt,
    output logic [NP-1:0]       max_addr
);

    logic [PEAK_MAX-1:0] max_cnt_q, max_cnt_d;
    logic [NP-1:0]       max_addr_q, max_addr_d;

    // Strict compare keeps the earliest-arrived address on ties.
    always_comb begin
        max_cnt_d  = max_cnt_q;
        max_addr_d = max_addr_q;
        if (init || (en && (in_cnt > max_cnt_q))) begin
            max_cnt_d  = in_cnt;
            max_addr_d = in_addr;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            max_cnt_q  <= '0;
            max_addr_q <= '0;
        end else begin
            max_cnt_q  <= max_cnt_d;
            max_addr_q <= max_addr_d;
        end
    end

    assign max_cnt  = max_cnt_q;
    assign max_addr = max_addr_q;

endmodule

// File: rtl/his_peak_finder.sv
// rtl/his_peak_finder.sv - scans streamed coarse/fine histogram bins and publishes the peak bin
module his_peak_finder
    import his_peak_finder_pkg::*;
#(
    parameter int NP       = NP_DEF,
    parameter int PEAK_MAX = PEAK_MAX_DEF,
    parameter int NB       = NB_DEF
) (
    input  logic                clk,
    input  logic                res,
    input  logic [PEAK_MAX-1:0] binCounts,
    input  logic [NP-1:0]       addr,
    input  logic [1:0]          dataFinish,
    output logic [NP-1:0]       peakCH,
    output logic [NP-1:0]       peakFH,
    output logic [PEAK_MAX-1:0] peakCount,
    output logic                chValid,
    output logic                fhValid,
    output logic                err
);

    localparam int BCW = NP + 1;

    typedef enum logic [1:0] {IDLE, SCAN_CH, SCAN_FH} state_t;

    state_t              state_q, state_d, bin_state;
    logic [BCW-1:0]      bin_cnt_q, bin_cnt_d;
    logic [NP-1:0]       peak_ch_q, peak_ch_d, peak_fh_q, peak_fh_d;
    logic [PEAK_MAX-1:0] peak_count_q, peak_count_d;
    logic                ch_valid_q, ch_valid_d, fh_valid_q, fh_valid_d;
    logic                err_q, err_d;
    logic                trk_init, trk_en, fresh, bad_addr;
    logic [PEAK_MAX-1:0] run_cnt;
    logic [NP-1:0]       run_addr;

    his_max_tracker #(.NP(NP), .PEAK_MAX(PEAK_MAX)) u_tracker (
        .clk      (clk),
        .res      (res),
        .init     (trk_init),
        .en       (trk_en),
        .in_cnt   (binCounts),
        .in_addr  (addr),
        .max_cnt  (run_cnt),
        .max_addr (run_addr)
    );

    always_comb begin
        state_d      = state_q;
        bin_cnt_d    = bin_cnt_q;
        peak_ch_d    = peak_ch_q;
        peak_fh_d    = peak_fh_q;
        peak_count_d = peak_count_q;
        ch_valid_d   = 1'b0;
        fh_valid_d   = 1'b0;
        err_d        = err_q;
        trk_init     = 1'b0;
        trk_en       = 1'b0;
        bin_state    = (dataFinish == DF_CH) ? SCAN_CH : SCAN_FH;
        fresh        = (state_q != bin_state);
        bad_addr     = (addr == '0) || ((dataFinish == DF_CH) && (32'(addr) > NB));

        case (dataFinish)
            DF_CH, DF_FH: begin
                state_d = bin_state;
                // A type switch mid-scan drops the old scan and restarts on this bin.
                if (fresh) begin
                    bin_cnt_d = '0;
                    if (state_q != IDLE) err_d = 1'b1;
                end
                if (bad_addr) begin
                    err_d = 1'b1;
                end else if (fresh || (bin_cnt_q == '0)) begin
                    trk_init  = 1'b1;
                    bin_cnt_d = BCW'(1);
                end else begin
                    trk_en = 1'b1;
                    if (bin_cnt_q != '1) bin_cnt_d = bin_cnt_q + BCW'(1);
                end
            end
            DF_END: begin
                state_d = IDLE;
                // No accepted bins means there is no peak to publish.
                if ((state_q == IDLE) || (bin_cnt_q == '0)) begin
                    err_d = 1'b1;
                end else if (state_q == SCAN_CH) begin
                    peak_ch_d    = run_addr;
                    peak_count_d = run_cnt;
                    ch_valid_d   = 1'b1;
                end else begin
                    peak_fh_d    = run_addr;
                    peak_count_d = run_cnt;
                    fh_valid_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            bin_cnt_q    <= '0;
            peak_ch_q    <= '0;
            peak_fh_q    <= '0;
            peak_count_q <= '0;
            ch_valid_q   <= 1'b0;
            fh_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            peak_ch_q    <= peak_ch_d;
            peak_fh_q    <= peak_fh_d;
            peak_count_q <= peak_count_d;
            ch_valid_q   <= ch_valid_d;
            fh_valid_q   <= fh_valid_d;
            err_q        <= err_d;
        end
    end

    assign peakCH    = peak_ch_q;
    assign peakFH    = peak_fh_q;
    assign peakCount = peak_count_q;
    assign chValid   = ch_valid_q;
    assign fhValid   = fh_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_his_peak_finder.sv
// tb/tb_his_peak_finder.sv - directed self-checking bench for his_peak_finder
module tb_his_peak_finder;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [7:0] binCounts = '0;
    logic [7:0] addr = '0;
    logic [1:0] dataFinish = 2'b00;
    logic [7:0] peakCH, peakFH, peakCount;
    logic       chValid, fhValid, err;

    int checks = 0;
    int errors = 0;

    his_peak_finder #(.NP(8), .PEAK_MAX(8), .NB(16)) dut (
        .clk        (clk),
        .res        (res),
        .binCounts  (binCounts),
        .addr       (addr),
        .dataFinish (dataFinish),
        .peakCH     (peakCH),
        .peakFH     (peakFH),
        .peakCount  (peakCount),
        .chValid    (chValid),
        .fhValid    (fhValid),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] df, input logic [7:0] a, input logic [7:0] c);
        @(negedge clk);
        dataFinish = df;
        addr       = a;
        binCounts  = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res        = 1'b1;
        dataFinish = 2'b00;
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ch, input logic [7:0] fh,
                             input logic [7:0] cnt, input logic cv, input logic fv, input logic e);
        chk({tag, ".peakCH"}, 32'(peakCH), 32'(ch));
        chk({tag, ".peakFH"}, 32'(peakFH), 32'(fh));
        chk({tag, ".peakCount"}, 32'(peakCount), 32'(cnt));
        chk({tag, ".chValid"}, 32'(chValid), 32'(cv));
        chk({tag, ".fhValid"}, 32'(fhValid), 32'(fv));
        chk({tag, ".err"}, 32'(err), 32'(e));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_out("reset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        res = 1'b0;

        // End marker straight from idle: empty histogram
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("empty", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        do_reset();

        // CH with tie on count 7: earliest address wins
        put(2'b01, 8'd1, 8'd3);
        put(2'b01, 8'd2, 8'd7);
        put(2'b01, 8'd3, 8'd7);
        put(2'b01, 8'd4, 8'd2);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("ch_tie", 8'd2, 8'd0, 8'd7, 1'b1, 1'b0, 1'b0);
        put(2'b00, 8'd0, 8'd0);
        check_out("ch_tie_after", 8'd2, 8'd0, 8'd7, 1'b0, 1'b0, 1'b0);

        // All-zero FH: first bin wins, CH result untouched
        put(2'b10, 8'd5, 8'd0);
        put(2'b10, 8'd6, 8'd0);
        put(2'b10, 8'd7, 8'd0);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("fh_zero", 8'd2, 8'd5, 8'd0, 1'b0, 1'b1, 1'b0);
        put(2'b00, 8'd0, 8'd0);
        chk("fh_zero_after.fhValid", 32'(fhValid), 32'd0);

        // Stalls plus out-of-range CH address
        put(2'b01, 8'd1, 8'd4);
        repeat (3) put(2'b00, 8'd0, 8'd0);
        put(2'b01, 8'd17, 8'd9);
        put(2'b01, 8'd2, 8'd5);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("ch_oob", 8'd2, 8'd5, 8'd5, 1'b1, 1'b0, 1'b1);
        do_reset();

        // Type switch mid-scan discards the CH scan
        put(2'b01, 8'd1, 8'd8);
        put(2'b01, 8'd2, 8'd9);
        put(2'b10, 8'd3, 8'd1);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("switch", 8'd0, 8'd3, 8'd1, 1'b0, 1'b1, 1'b1);
        do_reset();

        // Reset mid-scan: the following end marker is an empty histogram
        put(2'b01, 8'd3, 8'd9);
        do_reset();
        chk("midreset.err", 32'(err), 32'd0);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("midreset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        do_reset();

        // Address NB is legal for CH; FH accepts addresses above NB; addr 0 rejected
        put(2'b01, 8'd16, 8'd10);
        put(2'b01, 8'd4, 8'd10);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("ch_nb", 8'd16, 8'd0, 8'd10, 1'b1, 1'b0, 1'b0);
        put(2'b10, 8'd200, 8'd3);
        put(2'b10, 8'd1, 8'd2);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("fh_high", 8'd16, 8'd200, 8'd3, 1'b0, 1'b1, 1'b0);
        put(2'b10, 8'd9, 8'd4);
        put(2'b10, 8'd0, 8'd255);
        put(2'b10, 8'd10, 8'd6);
        put(2'b11, 8'd0, 8'd0);
        put(2'b00, 8'd0, 8'd0);
        check_out("fh_addr0", 8'd16, 8'd10, 8'd6, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
